// File: rtl/demux_frame_collector.sv
// demux_frame_collector: registered 1-to-NR_LANE beat demux that assembles a frame.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_sel/auto_mode
//   beat input; out_lanes, lane_written, frame_valid frame output; frame_ack consumer ack.
module demux_frame_collector #(
    parameter int NR_LANE  = 4,
    parameter int SEL_LEN  = 2,
    parameter int DATA_LEN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_LEN-1:0]          in_data,
    input  logic [SEL_LEN-1:0]           in_sel,
    input  logic                         auto_mode,
    output logic [NR_LANE*DATA_LEN-1:0]  out_lanes,
    output logic [NR_LANE-1:0]           lane_written,
    output logic                         frame_valid,
    input  logic                         frame_ack
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;

    localparam logic [SEL_LEN:0]   LANE_CNT  = (SEL_LEN+1)'(NR_LANE);
    localparam logic [SEL_LEN-1:0] LANE_LAST = SEL_LEN'(NR_LANE - 1);

    state_t              state;
    state_t              state_next;
    logic [SEL_LEN-1:0]  ptr;
    logic [SEL_LEN-1:0]  lane;
    logic                lane_ok;
    logic                accept;
    logic                wr_en;
    logic [NR_LANE-1:0]  lane_dec;
    logic [NR_LANE-1:0]  written_next;

    assign in_ready    = (state == FILL);
    assign frame_valid = (state == HOLD);

    assign accept  = in_valid & in_ready;
    assign lane    = auto_mode ? ptr : in_sel;
    // A manual select past the last lane is consumed but writes nothing.
    assign lane_ok = ({1'b0, lane} < LANE_CNT);
    assign wr_en   = accept & lane_ok;

    always_comb begin
        lane_dec = '0;
        for (int i = 0; i < NR_LANE; i++) begin
            lane_dec[i] = wr_en && (lane == SEL_LEN'(i));
        end
    end

    // Completion includes the bit of the beat being accepted this cycle.
    assign written_next = lane_written | lane_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = FILL;
            FILL: begin
                if (wr_en && (&written_next)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_next = FILL;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_lanes    <= '0;
            lane_written <= '0;
            ptr          <= '0;
        end else if (frame_valid && frame_ack) begin
            // Lane data is kept; only the fill bookkeeping restarts.
            lane_written <= '0;
            ptr          <= '0;
        end else if (accept) begin
            lane_written <= written_next;
            for (int i = 0; i < NR_LANE; i++) begin
                if (lane_dec[i]) begin
                    out_lanes[i*DATA_LEN +: DATA_LEN] <= in_data;
                end
            end
            if (auto_mode) begin
                ptr <= (ptr == LANE_LAST) ? '0 : ptr + 1'b1;
            end
        end
    end

endmodule
